// File: rtl/alu.sv
// rtl/alu.sv - 32-bit ALU with a one-cycle registered result, Zero and Overflow flags
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUOp,
    output logic [31:0] C,
    output logic        Zero,
    output logic        Overflow
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_SRL  = 3'b100,
        OP_SRA  = 3'b101,
        OP_SLT  = 3'b110,
        OP_SLTU = 3'b111
    } alu_op_t;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        ovf;

    assign sum   = A + B;
    assign diff  = A - B;
    assign shamt = B[4:0];

    always_comb begin
        result = 32'h0;
        ovf    = 1'b0;
        case (alu_op_t'(ALUOp))
            OP_ADD: begin
                result = sum;
                ovf    = (A[31] == B[31]) && (sum[31] != A[31]);
            end
            OP_SUB: begin
                result = diff;
                ovf    = (A[31] != B[31]) && (diff[31] != A[31]);
            end
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_SRL:  result = A >> shamt;
            OP_SRA:  result = $unsigned($signed(A) >>> shamt);
            OP_SLT:  result = {31'h0, $signed(A) < $signed(B)};
            OP_SLTU: result = {31'h0, A < B};
            default: result = 32'h0;
        endcase
    end

    // Zero is derived from the same result that lands in C, so the two never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            C        <= 32'h0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
        end else begin
            C        <= result;
            Zero     <= (result == 32'h0);
            Overflow <= ovf;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu against an arithmetic reference model
module tb_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUOp;
    logic [31:0] C;
    logic        Zero;
    logic        Overflow;

    int checks = 0;
    int errors = 0;

    alu dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .ALUOp    (ALUOp),
        .C        (C),
        .Zero     (Zero),
        .Overflow (Overflow)
    );

    always #5 clk = ~clk;

    // Returns {overflow, result} computed with wide signed/unsigned integer arithmetic.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        longint sa, sb, ua, ub, r, pw;
        logic [31:0] c;
        logic        ov;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        pw = longint'(1) << b[4:0];
        ov = 1'b0;
        c  = 32'h0;
        case (op)
            3'd0: begin r = sa + sb; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); c = r[31:0]; end
            3'd1: begin r = sa - sb; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); c = r[31:0]; end
            3'd2: c = a & b;
            3'd3: c = a | b;
            3'd4: begin r = ua / pw; c = r[31:0]; end
            3'd5: begin r = (sa >= 0) ? sa / pw : -((-sa + pw - 1) / pw); c = r[31:0]; end
            3'd6: c = (sa < sb) ? 32'd1 : 32'd0;
            default: c = (ua < ub) ? 32'd1 : 32'd0;
        endcase
        return {ov, c};
    endfunction

    task automatic check_out(input string tag, input logic [31:0] ec, input logic ez, input logic eo);
        checks++;
        assert (C === ec) else begin
            errors++;
            $error("FAIL %s C observed %h expected %h", tag, C, ec);
        end
        checks++;
        assert (Zero === ez) else begin
            errors++;
            $error("FAIL %s Zero observed %b expected %b", tag, Zero, ez);
        end
        checks++;
        assert (Overflow === eo) else begin
            errors++;
            $error("FAIL %s Overflow observed %b expected %b", tag, Overflow, eo);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [32:0] m;
        A = a; B = b; ALUOp = op;
        m = model(a, b, op);
        @(posedge clk); #1;
        check_out(tag, m[31:0], m[31:0] == 32'h0, m[32]);
    endtask

    task automatic run_exp(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic [31:0] ec, input logic eo);
        A = a; B = b; ALUOp = op;
        @(posedge clk); #1;
        check_out(tag, ec, ec == 32'h0, eo);
    endtask

    logic [31:0] ra, rb;
    logic [2:0]  rop;
    logic [31:0] edge_vals [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0000001F};

    initial begin
        reset = 1'b1; A = 32'hDEADBEEF; B = 32'h12345678; ALUOp = 3'b000;
        @(posedge clk); #1;
        check_out("reset", 32'h0, 1'b1, 1'b0);
        reset = 1'b0;

        run_exp("sub_neg",   32'h8,        32'hF,        3'b001, 32'hFFFFFFF9, 1'b0);
        run_exp("add_ovf",   32'h7FFFFFFF, 32'h1,        3'b000, 32'h80000000, 1'b1);
        run_exp("sub_zero",  32'h5,        32'h5,        3'b001, 32'h0,        1'b0);
        run_exp("and",       32'hF0F0F0F0, 32'h0FF00FF0, 3'b010, 32'h00F000F0, 1'b0);
        run_exp("or",        32'hF0F0F0F0, 32'h0FF00FF0, 3'b011, 32'hFFF0FFF0, 1'b0);
        run_exp("srl",       32'h80000000, 32'h24,       3'b100, 32'h08000000, 1'b0);
        run_exp("sra",       32'h80000000, 32'h24,       3'b101, 32'hF8000000, 1'b0);
        run_exp("slt",       32'hFFFFFFFF, 32'h1,        3'b110, 32'h1,        1'b0);
        run_exp("sltu",      32'hFFFFFFFF, 32'h1,        3'b111, 32'h0,        1'b0);
        run_exp("srl_sh0",   32'h9ABCDEF0, 32'hFFFFFFE0, 3'b100, 32'h9ABCDEF0, 1'b0);
        run_exp("sra_sh0",   32'h9ABCDEF0, 32'h00000020, 3'b101, 32'h9ABCDEF0, 1'b0);
        run_exp("sub_ovf",   32'h80000000, 32'h1,        3'b001, 32'h7FFFFFFF, 1'b1);
        run_exp("add_wrap",  32'hFFFFFFFF, 32'h1,        3'b000, 32'h0,        1'b0);
        run_exp("and_noovf", 32'h7FFFFFFF, 32'h7FFFFFFF, 3'b010, 32'h7FFFFFFF, 1'b0);

        // Mid-stream reset discards the pending result; first released edge takes current inputs.
        A = 32'h7FFFFFFF; B = 32'h1; ALUOp = 3'b000; reset = 1'b1;
        @(posedge clk); #1;
        check_out("reset_mid", 32'h0, 1'b1, 1'b0);
        reset = 1'b0;
        run_exp("post_reset", 32'h7FFFFFFF, 32'h1, 3'b000, 32'h80000000, 1'b1);

        for (int i = 0; i < 300; i++) begin
            ra  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            rop = 3'($urandom_range(0, 7));
            run_op("random", ra, rb, rop);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single rising-edge clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have the port A, input, 32 bits: first operand.
REQ-004 The block SHALL have the port B, input, 32 bits: second operand; B[4:0] is the shift amount for shift ops.
REQ-005 The block SHALL have the port ALUOp, input, 3 bits: operation select.
REQ-006 The block SHALL have the port C, output, 32 bits: registered result.
REQ-007 The block SHALL have the port Zero, output, 1 bit: registered flag, 1 when the registered C equals 0.
REQ-008 The block SHALL have the port Overflow, output, 1 bit: registered signed-overflow flag for add/sub; 0 for all other ops.
REQ-009 The block SHALL have no parameters; data width is fixed at 32.

Function
REQ-010 The block SHALL compute its result combinationally from A, B and ALUOp and register it into C on every rising edge of clk when reset is 0.
REQ-011 The block SHALL have a latency of exactly 1 cycle: inputs sampled at edge N appear on C/Zero/Overflow after edge N.
REQ-012 The block SHALL hold the outputs stable between edges; there is no enable and no handshake.
REQ-013 The block SHALL implement ALUOp=000 as add: C = (A + B) mod 2^32, carry discarded.
REQ-014 The block SHALL implement ALUOp=001 as subtract: C = (A - B) mod 2^32, two's complement wrap.
REQ-015 The block SHALL implement ALUOp=010 as bitwise AND: C = A & B.
REQ-016 The block SHALL implement ALUOp=011 as bitwise OR: C = A | B.
REQ-017 The block SHALL implement ALUOp=100 as logical right shift: C = A >> B[4:0], zero fill; B[31:5] ignored.
REQ-018 The block SHALL implement ALUOp=101 as arithmetic right shift: C = A >>> B[4:0], sign fill from A[31]; B[31:5] ignored.
REQ-019 The block SHALL implement ALUOp=110 as signed set-less-than: C = 32'd1 if $signed(A) < $signed(B), else 32'd0.
REQ-020 The block SHALL implement ALUOp=111 as unsigned set-less-than: C = 32'd1 if A < B unsigned, else 32'd0.
REQ-021 The block SHALL set Overflow = 1 for add when A[31] == B[31] and the result[31] differs from A[31].
REQ-022 The block SHALL set Overflow = 1 for subtract when A[31] != B[31] and the result[31] differs from A[31].
REQ-023 The block SHALL set Zero from the same-cycle result being registered, so Zero and C are always mutually consistent.
REQ-024 The block SHALL treat a shift amount of 0 as C = A for ALUOp 100 and 101.
REQ-025 The block SHALL treat any X or Z on the inputs as don't-care; no special handling is required.

Reset
REQ-026 When reset is 1 at a rising edge, the block SHALL set C = 32'h0, Zero = 1 and Overflow = 0, regardless of the other inputs.
REQ-027 Reset SHALL take priority over computation; on the first edge with reset = 0, the block SHALL register the result of the current inputs.
REQ-028 Reset asserted mid-stream SHALL discard the pending result; no result is carried over.

Verification
REQ-029 The bench SHALL cover this case: reset=1 for one edge -> C=0, Zero=1, Overflow=0.
REQ-030 The bench SHALL cover this case: A=32'h8, B=32'hF, ALUOp=001 -> after one edge C=32'hFFFFFFF9, Zero=0, Overflow=0.
REQ-031 The bench SHALL cover this case: A=32'h7FFFFFFF, B=32'h1, ALUOp=000 -> C=32'h80000000, Overflow=1; A=32'h5, B=32'h5, ALUOp=001 -> C=0, Zero=1.
REQ-032 The bench SHALL cover this case: A=32'hF0F0F0F0, B=32'h0FF00FF0, ALUOp=010 -> C=32'h00F000F0; ALUOp=011 -> C=32'hFFF0FFF0.
REQ-033 The bench SHALL cover this case: A=32'h80000000, B=32'h24 (shift 4), ALUOp=100 -> C=32'h08000000; ALUOp=101 -> C=32'hF8000000.
REQ-034 The bench SHALL cover this case: A=32'hFFFFFFFF, B=32'h1, ALUOp=110 -> C=1; ALUOp=111 -> C=0.
